// File: rtl/funnel_pipe_serializer.sv
// Serializes one wide packed message per enq into BEATS narrow beats,
// least-significant beat first, with no bubble between back-to-back messages.
module funnel_pipe_serializer #(
  parameter int unsigned IN_WIDTH  = 128,
  parameter int unsigned OUT_WIDTH = 32,
  parameter int unsigned BEATS     = IN_WIDTH / OUT_WIDTH
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 in_enq__ENA,
  input  logic [IN_WIDTH-1:0]  in_enq_v,
  output logic                 in_enq__RDY,
  input  logic                 out_enq__RDY,
  output logic                 out_enq__ENA,
  output logic [OUT_WIDTH-1:0] out_enq_v,
  output logic                 out_last,
  output logic [15:0]          msg_count
);

  localparam int unsigned BW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                            state_q, state_d;
  logic [BEATS-1:0][OUT_WIDTH-1:0]   hold_q, hold_d;
  logic [BW-1:0]                     beat_q, beat_d;
  logic [15:0]                       msg_count_q, msg_count_d;
  logic                              sending;
  logic                              take;

  always_comb begin
    sending      = (state_q == SEND);
    out_last     = sending && (beat_q == LAST_BEAT);
    out_enq__ENA = sending && out_enq__RDY;
    out_enq_v    = sending ? hold_q[beat_q] : '0;
    // Gated by nRST so the upstream sees not-ready while reset is held.
    in_enq__RDY  = nRST && (!sending || (out_last && out_enq__RDY));
    take         = in_enq__ENA && in_enq__RDY;
    msg_count    = msg_count_q;
  end

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    beat_d      = beat_q;
    msg_count_d = msg_count_q;
    if (out_enq__ENA) begin
      if (out_last) begin
        msg_count_d = msg_count_q + 16'd1;
        state_d     = IDLE;
      end else begin
        beat_d = beat_q + BW'(1);
      end
    end
    // A load on the final beat overrides the return to IDLE.
    if (take) begin
      hold_d  = in_enq_v;
      beat_d  = '0;
      state_d = SEND;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      beat_q      <= '0;
      msg_count_q <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      beat_q      <= beat_d;
      msg_count_q <= msg_count_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (nRST) begin
      assert (!in_enq__ENA || in_enq__RDY)
        else $error("in_enq__ENA asserted while in_enq__RDY low");
    end
  end

endmodule

// File: tb/tb_funnel_pipe_serializer.sv
// Scoreboard bench for funnel_pipe_serializer: expected beats are queued at
// enq time and checked by a negedge monitor as the DUT emits them.
module tb_funnel_pipe_serializer;

  logic          CLK = 1'b0;
  logic          nRST = 1'b0;
  logic          in_enq__ENA = 1'b0;
  logic [127:0]  in_enq_v = '0;
  logic          in_enq__RDY;
  logic          out_enq__RDY = 1'b1;
  logic          out_enq__ENA;
  logic [31:0]   out_enq_v;
  logic          out_last;
  logic [15:0]   msg_count;

  funnel_pipe_serializer #(.IN_WIDTH(128), .OUT_WIDTH(32), .BEATS(4)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .in_enq__ENA  (in_enq__ENA),
    .in_enq_v     (in_enq_v),
    .in_enq__RDY  (in_enq__RDY),
    .out_enq__RDY (out_enq__RDY),
    .out_enq__ENA (out_enq__ENA),
    .out_enq_v    (out_enq_v),
    .out_last     (out_last),
    .msg_count    (msg_count)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } beat_t;

  beat_t       sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [15:0] exp_count = '0;

  localparam logic [127:0] M1 = 128'h00050000_DEADBEEF_00000000_00000040;
  localparam logic [127:0] M2 = 128'h44443333_22221111_A5A5A5A5_0000000C;

  // Monitor: every transfer must match the head of the scoreboard.
  always @(negedge CLK) begin
    beat_t b;
    if (nRST && out_enq__ENA) begin
      tests_run++;
      if (out_enq__RDY !== 1'b1) begin
        tests_failed++;
        $display("FAIL ena_without_rdy: ENA=1 RDY=%b", out_enq__RDY);
      end
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL unexpected_beat: got data=%h last=%b, none expected", out_enq_v, out_last);
      end else begin
        b = sb.pop_front();
        if (out_enq_v !== b.d || out_last !== b.l) begin
          tests_failed++;
          $display("FAIL beat: got data=%h last=%b, expected data=%h last=%b",
                   out_enq_v, out_last, b.d, b.l);
        end
        if (b.l) exp_count = exp_count + 16'd1;
      end
    end
  end

  task automatic push_msg(input logic [127:0] m);
    beat_t b;
    for (int i = 0; i < 4; i++) begin
      b.d = m[i*32 +: 32];
      b.l = (i == 3);
      sb.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
  task automatic enq(input logic [127:0] m);
    int n = 0;
    while (in_enq__RDY !== 1'b1 && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 50) begin
      tests_run++;
      tests_failed++;
      $display("FAIL enq_timeout: in_enq__RDY=%b after %0d cycles, expected 1", in_enq__RDY, n);
    end else begin
      in_enq__ENA = 1'b1;
      in_enq_v    = m;
      push_msg(m);
      @(posedge CLK); #1;
      in_enq__ENA = 1'b0;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge CLK); #1;
      n++;
    end
    if (sb.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check_count(input string name);
    tests_run++;
    if (msg_count !== exp_count) begin
      tests_failed++;
      $display("FAIL %s: msg_count=%h expected %h", name, msg_count, exp_count);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    #12;
    tests_run++;
    if (in_enq__RDY !== 1'b0 || out_enq__ENA !== 1'b0 || out_last !== 1'b0 ||
        out_enq_v !== 32'h0 || msg_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs: rdy=%b ena=%b last=%b v=%h cnt=%h expected 0,0,0,0,0",
               in_enq__RDY, out_enq__ENA, out_last, out_enq_v, msg_count);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      tests_run++;
      if (in_enq__RDY !== 1'b1 || out_enq__ENA !== 1'b0 || msg_count !== 16'h0) begin
        tests_failed++;
        $display("FAIL idle_after_reset: rdy=%b ena=%b cnt=%h expected 1,0,0000",
                 in_enq__RDY, out_enq__ENA, msg_count);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_single();
    out_enq__RDY = 1'b1;
    enq(M1);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      tests_run++;
      if (out_enq__ENA !== 1'b1 || out_last !== (i == 3)) begin
        tests_failed++;
        $display("FAIL single_cycle%0d: ena=%b last=%b expected 1,%b", i, out_enq__ENA, out_last, (i == 3));
      end
    end
    @(posedge CLK); #1;
    drain();
    check_count("single_count");
  endtask

  task automatic test_backpressure();
    logic [6:0]  pat = 7'b1011001;
    logic [31:0] prev_v = '0;
    logic        prev_rdy = 1'b1;
    enq(M1);
    for (int i = 0; i < 7; i++) begin
      out_enq__RDY = pat[i];
      @(negedge CLK);
      tests_run++;
      if (out_enq__ENA !== pat[i]) begin
        tests_failed++;
        $display("FAIL bp_ena%0d: ena=%b expected %b", i, out_enq__ENA, pat[i]);
      end
      if (!prev_rdy) begin
        tests_run++;
        if (out_enq_v !== prev_v) begin
          tests_failed++;
          $display("FAIL bp_stable%0d: v=%h expected %h", i, out_enq_v, prev_v);
        end
      end
      prev_v   = out_enq_v;
      prev_rdy = pat[i];
      @(posedge CLK); #1;
    end
    out_enq__RDY = 1'b1;
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL bp_all_beats: %0d beats outstanding, expected 0", sb.size());
    end
    drain();
    check_count("bp_count");
  endtask

  task automatic test_back_to_back();
    out_enq__RDY = 1'b1;
    enq(M1);
    fork
      enq(M2);
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge CLK);
          tests_run++;
          if (out_enq__ENA !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_gap%0d: ena=%b expected 1", i, out_enq__ENA);
          end
        end
      end
    join
    @(posedge CLK); #1;
    drain();
    check_count("b2b_count");
  endtask

  task automatic test_mid_reset();
    out_enq__RDY = 1'b1;
    enq(M2);
    repeat (3) @(negedge CLK);
    #1;
    nRST = 1'b0;
    sb.delete();
    exp_count = '0;
    #1;
    tests_run++;
    if (in_enq__RDY !== 1'b0 || out_enq__ENA !== 1'b0 || out_last !== 1'b0 ||
        out_enq_v !== 32'h0 || msg_count !== 16'h0) begin
      tests_failed++;
      $display("FAIL midreset_outputs: rdy=%b ena=%b last=%b v=%h cnt=%h expected 0,0,0,0,0",
               in_enq__RDY, out_enq__ENA, out_last, out_enq_v, msg_count);
    end
    @(posedge CLK); #1;
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      tests_run++;
      if (out_enq__ENA !== 1'b0 || msg_count !== 16'h0) begin
        tests_failed++;
        $display("FAIL midreset_residual%0d: ena=%b cnt=%h expected 0,0000", i, out_enq__ENA, msg_count);
      end
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_wrap();
    out_enq__RDY = 1'b1;
    force dut.msg_count_q = 16'hFFFE;
    @(posedge CLK); #1;
    release dut.msg_count_q;
    exp_count = 16'hFFFE;
    @(posedge CLK); #1;
    check_count("wrap_preload");
    for (int i = 0; i < 3; i++) begin
      enq((i == 1) ? M2 : M1);
      drain();
      check_count("wrap_count");
    end
    tests_run++;
    if (msg_count !== 16'h0001) begin
      tests_failed++;
      $display("FAIL wrap_final: msg_count=%h expected 0001", msg_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_mid_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
